lcd_spi_rx_decoder: RTL
=======================

// Module: lcd_spi_rx_decoder
// PURPOSE
//  SPI slave / LCD-controller end of the 4-wire display link (SCLK, MOSI, DC, CS_n): deserialises
//  bytes, decodes CASET/PASET/RAMWR, tracks the column/page window and emits one strobe per
//  RGB565 pixel with its (x,y) address. Used as the on-FPGA display model for loopback test
//  designs and as the checker endpoint for the clear/draw controllers. Receive-only; no MISO.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser depth applied identically to sclk, mosi, dc, cs_n
//  CMD_CASET    8'h2A  column-address-set opcode (4 argument bytes)
//  CMD_PASET    8'h2B  page-address-set opcode (4 argument bytes)
//  CMD_RAMWR    8'h2C  memory-write opcode (unbounded pixel data follows)
//  MAX_X        239    reset value of col_end; 9-bit field
//  MAX_Y        319    reset value of page_end; 9-bit field
// PORTS
//  i_clk         in   1   system clock; must be >= 4x SCLK frequency
//  i_rst         in   1   reset, asynchronous, active-high
//  i_sclk        in   1   SPI clock, mode 0, sampled on rising edge
//  i_mosi        in   1   serial data, MSB first
//  i_dc          in   1   0 = command byte, 1 = data byte (sampled with bit 7, the last bit)
//  i_cs_n        in   1   chip select, active-low
//  o_cmd_valid   out  1   1-cycle pulse: command byte received
//  o_cmd         out  8   last command opcode (held)
//  o_pix_valid   out  1   1-cycle pulse: pixel complete
//  o_pix_data    out  16  pixel {first byte, second byte}
//  o_pix_x       out  9   column of the pixel on o_pix_data
//  o_pix_y       out  9   page (row) of the pixel on o_pix_data
//  o_frame_done  out  1   1-cycle pulse with the pixel at (col_end,page_end)
//  o_err         out  1   1-cycle pulse: data byte with no active command, or short argument list
// BEHAVIOUR
//  - Reset: all pulses 0, o_cmd=0, o_pix_*=0, col window 0..MAX_X, page window 0..MAX_Y,
//    decoder IDLE, bit count 0, pixel half-register empty.
//  - Front end: all four inputs through SYNC_STAGES flops; sclk rising edge = sync(n)&~sync(n-1).
//    On edge with cs_n low: shift mosi into 8-bit register, bitcnt++. At bitcnt wrap 7->0,
//    byte strobe asserts one cycle later with the byte and the dc sampled on that edge.
//  - cs_n high: bitcnt forced to 0, partial byte discarded; decoder state and pixel address KEPT
//    (a RAMWR stream may span several CS frames).
//  - Decoder states: IDLE, CASET_ARG(0..3), PASET_ARG(0..3), RAMWR.
//    cmd byte (dc=0), any state: o_cmd<=byte, o_cmd_valid pulse; pending pixel half dropped;
//      if in CASET_ARG/PASET_ARG with <4 args received -> o_err pulse, window unchanged.
//      CASET->CASET_ARG0, PASET->PASET_ARG0, RAMWR->RAMWR with x=col_start,y=page_start,
//      other opcodes->IDLE (their data bytes silently ignored, no o_err).
//    data byte in ARGk: stage bytes as start[15:8], start[7:0], end[15:8], end[7:0];
//      after ARG3 commit start/end (low 9 bits) atomically, go IDLE.
//    data byte in RAMWR: first byte held; second byte -> o_pix_valid next cycle with
//      o_pix_data/x/y; then x++; if x==col_end: x<=col_start, y++; if also y==page_end:
//      y<=page_start, o_frame_done with that pixel.
//    data byte in IDLE after reset (no command yet) -> o_err pulse.
//  - Degenerate windows (start>end): wrap compare is equality only; x counts to 511 and wraps
//    mod 512 -- defined, not an error.
//  - Throughput: at most one byte strobe per 8 sclk edges; no back-pressure, no buffering.
//  - Reset mid-operation: immediate return to reset values; no pulse emitted on the reset edge.
// STRUCTURE
//  - Shared package lcd_spi_pkg: opcode constants (CASET/PASET/RAMWR), decoder state enum,
//    9-bit coordinate type; also imported by the transmit-side controllers.
//  - One sub-module: spi_byte_rx (sync + edge detect + shifter + cs_n abort -> byte/dc strobe).
//    Decoder FSM and address counters stay in this file.
// TESTING
//  1 CASET 00 00 00 EF, PASET 00 00 00 07, RAMWR, 3840 x 8'h00 -> 1920 o_pix_valid, data 0,
//    first (0,0), last (239,7) with o_frame_done; 3 o_cmd_valid pulses, no o_err.
//  2 CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR, 8 bytes 12 34 .. -> pixels (10,20)(11,20)
//    (10,21)(11,21), 4th with o_frame_done; next 2 bytes -> pixel at (10,20).
//  3 5 bits shifted then cs_n high, then full byte 2C with dc=0 -> o_cmd=2C only; partial lost.
//  4 After reset, data byte 55 (dc=1) -> o_err pulse; CASET + 2 args + RAMWR -> o_err,
//    window stays 0..239.
//  5 RAMWR stream split across 3 CS frames, odd byte at a frame boundary -> pixels contiguous
//    and correctly paired.
//  6 i_rst asserted mid-RAMWR at pixel (5,3) -> outputs zero same cycle; after release,
//    data bytes -> o_err, window back to 0..239/0..319.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI link: opcodes, coordinate type and decoder states.
package lcd_spi_pkg;

  typedef logic [8:0] coord_t;

  localparam logic [7:0] CmdCaset = 8'h2A;
  localparam logic [7:0] CmdPaset = 8'h2B;
  localparam logic [7:0] CmdRamwr = 8'h2C;

  localparam coord_t MaxXDefault = 9'd239;
  localparam coord_t MaxYDefault = 9'd319;

  typedef enum logic [1:0] {
    StIdle,
    StCasetArg,
    StPasetArg,
    StRamwr
  } dec_state_e;

endpackage

// File: rtl/lcd_spi_rx_decoder_if.sv
// 4-wire display link as seen at the panel: master drives it, the decoder listens.
interface lcd_spi_rx_decoder_if;
  logic sclk;
  logic mosi;
  logic dc;
  logic cs_n;

  modport master (output sclk, output mosi, output dc, output cs_n);
  modport slave  (input  sclk, input  mosi, input  dc, input  cs_n);
endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the link, detects sclk rising edges and
// emits a one-cycle strobe with each completed byte and the dc level of its last bit.
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_cs_n,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc
);

  // Bit order within each stage: {sclk, mosi, dc, cs_n}
  logic [3:0] sync_d [SYNC_STAGES];
  logic [3:0] sync_q [SYNC_STAGES];
  logic       sclk_prev_q;
  logic [6:0] shift_d, shift_q;
  logic [2:0] bitcnt_d, bitcnt_q;
  logic       byte_valid_d, byte_valid_q;
  logic [7:0] byte_d, byte_q;
  logic       dc_d, dc_q;

  logic sclk_s, mosi_s, dc_s, cs_n_s, sclk_rise;

  assign {sclk_s, mosi_s, dc_s, cs_n_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Synchroniser chain shift.
  always_comb begin
    sync_d[0] = {i_sclk, i_mosi, i_dc, i_cs_n};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Shifter and bit counter; cs_n high discards any partial byte.
  always_comb begin
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    dc_d         = dc_q;
    if (cs_n_s) begin
      bitcnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d  = {shift_q[5:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = {shift_q, mosi_s};
        dc_d         = dc_s;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0001;
      end
      sclk_prev_q  <= 1'b0;
      shift_q      <= 7'd0;
      bitcnt_q     <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      dc_q         <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sclk_prev_q  <= sclk_s;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      dc_q         <= dc_d;
    end
  end

  assign o_byte_valid = byte_valid_q;
  assign o_byte       = byte_q;
  assign o_dc         = dc_q;

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// LCD controller model: decodes CASET/PASET/RAMWR from the SPI byte stream, tracks the
// address window and emits one strobe per RGB565 pixel with its (x,y) address.
module lcd_spi_rx_decoder
  import lcd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_CASET   = CmdCaset,
  parameter logic [7:0]  CMD_PASET   = CmdPaset,
  parameter logic [7:0]  CMD_RAMWR   = CmdRamwr,
  parameter coord_t      MAX_X       = MaxXDefault,
  parameter coord_t      MAX_Y       = MaxYDefault
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  lcd_spi_rx_decoder_if.slave  spi,
  output logic                 o_cmd_valid,
  output logic [7:0]           o_cmd,
  output logic                 o_pix_valid,
  output logic [15:0]          o_pix_data,
  output logic [8:0]           o_pix_x,
  output logic [8:0]           o_pix_y,
  output logic                 o_frame_done,
  output logic                 o_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sclk       (spi.sclk),
    .i_mosi       (spi.mosi),
    .i_dc         (spi.dc),
    .i_cs_n       (spi.cs_n),
    .o_byte_valid (byte_valid),
    .o_byte       (rx_byte),
    .o_dc         (rx_dc)
  );

  dec_state_e  state_d, state_q;
  logic [1:0]  arg_cnt_d, arg_cnt_q;
  coord_t      arg_start_d, arg_start_q;   // staged start, committed after the 4th arg
  logic        arg_end_hi_d, arg_end_hi_q;
  coord_t      col_start_d, col_start_q, col_end_d, col_end_q;
  coord_t      page_start_d, page_start_q, page_end_d, page_end_q;
  coord_t      x_d, x_q, y_d, y_q;
  logic        half_valid_d, half_valid_q;
  logic [7:0]  half_d, half_q;
  logic        cmd_seen_d, cmd_seen_q;     // distinguishes post-reset IDLE from IDLE after a command
  logic        cmd_valid_d, cmd_valid_q;
  logic [7:0]  cmd_d, cmd_q;
  logic        pix_valid_d, pix_valid_q;
  logic [15:0] pix_data_d, pix_data_q;
  coord_t      pix_x_d, pix_x_q, pix_y_d, pix_y_q;
  logic        frame_done_d, frame_done_q;
  logic        err_d, err_q;

  // Decoder FSM, window staging and pixel address stepping.
  always_comb begin
    state_d      = state_q;
    arg_cnt_d    = arg_cnt_q;
    arg_start_d  = arg_start_q;
    arg_end_hi_d = arg_end_hi_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    x_d          = x_q;
    y_d          = y_q;
    half_valid_d = half_valid_q;
    half_d       = half_q;
    cmd_seen_d   = cmd_seen_q;
    cmd_valid_d  = 1'b0;
    cmd_d        = cmd_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (byte_valid && !rx_dc) begin
      cmd_valid_d  = 1'b1;
      cmd_d        = rx_byte;
      cmd_seen_d   = 1'b1;
      half_valid_d = 1'b0;
      arg_cnt_d    = 2'd0;
      // Any state still collecting arguments has an incomplete list here.
      if (state_q == StCasetArg || state_q == StPasetArg) begin
        err_d = 1'b1;
      end
      if (rx_byte == CMD_CASET) begin
        state_d = StCasetArg;
      end else if (rx_byte == CMD_PASET) begin
        state_d = StPasetArg;
      end else if (rx_byte == CMD_RAMWR) begin
        state_d = StRamwr;
        x_d     = col_start_q;
        y_d     = page_start_q;
      end else begin
        state_d = StIdle;
      end
    end else if (byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if (!cmd_seen_q) begin
            err_d = 1'b1;
          end
        end
        StCasetArg, StPasetArg: begin
          arg_cnt_d = arg_cnt_q + 2'd1;
          unique case (arg_cnt_q)
            2'd0: arg_start_d[8]   = rx_byte[0];
            2'd1: arg_start_d[7:0] = rx_byte;
            2'd2: arg_end_hi_d     = rx_byte[0];
            default: begin
              state_d = StIdle;
              if (state_q == StCasetArg) begin
                col_start_d = arg_start_q;
                col_end_d   = {arg_end_hi_q, rx_byte};
              end else begin
                page_start_d = arg_start_q;
                page_end_d   = {arg_end_hi_q, rx_byte};
              end
            end
          endcase
        end
        StRamwr: begin
          if (!half_valid_q) begin
            half_valid_d = 1'b1;
            half_d       = rx_byte;
          end else begin
            half_valid_d = 1'b0;
            pix_valid_d  = 1'b1;
            pix_data_d   = {half_q, rx_byte};
            pix_x_d      = x_q;
            pix_y_d      = y_q;
            // Equality-only wrap so degenerate windows simply roll over mod 512.
            if (x_q == col_end_q) begin
              x_d = col_start_q;
              y_d = y_q + 9'd1;
              if (y_q == page_end_q) begin
                y_d          = page_start_q;
                frame_done_d = 1'b1;
              end
            end else begin
              x_d = x_q + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      arg_cnt_q    <= 2'd0;
      arg_start_q  <= '0;
      arg_end_hi_q <= 1'b0;
      col_start_q  <= '0;
      col_end_q    <= MAX_X;
      page_start_q <= '0;
      page_end_q   <= MAX_Y;
      x_q          <= '0;
      y_q          <= '0;
      half_valid_q <= 1'b0;
      half_q       <= 8'd0;
      cmd_seen_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= 8'd0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 16'd0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg_cnt_q    <= arg_cnt_d;
      arg_start_q  <= arg_start_d;
      arg_end_hi_q <= arg_end_hi_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      x_q          <= x_d;
      y_q          <= y_d;
      half_valid_q <= half_valid_d;
      half_q       <= half_d;
      cmd_seen_q   <= cmd_seen_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd        = cmd_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_data   = pix_data_q;
  assign o_pix_x      = pix_x_q;
  assign o_pix_y      = pix_y_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

endmodule
